// File: rtl/spi_slave_shifter_if.sv
// rtl/spi_slave_shifter_if.sv - SPI slave shifter strobe, word and status bundle
`timescale 1ns/1ps

interface spi_slave_shifter_if;
    logic       ss_n;
    logic       mosi_in;
    logic       cpha;
    logic       sample_edge;
    logic       transmit_edge;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       miso_out;
    logic       miso_oe;
    logic       busy;

    modport master (
        output ss_n, mosi_in, cpha, sample_edge, transmit_edge,
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun,
        input  miso_out, miso_oe, busy
    );

    modport slave (
        input  ss_n, mosi_in, cpha, sample_edge, transmit_edge,
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_underrun, rx_data, rx_valid, rx_overrun,
        output miso_out, miso_oe, busy
    );
endinterface

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI slave byte shifter with tx/rx word handshakes
`timescale 1ns/1ps

module spi_slave_shifter #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    spi_slave_shifter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_cnt;
    logic       r_first_tx;
    logic       r_reload;
    logic       r_miso_out;
    logic       r_miso_oe;
    logic       r_busy;
    logic       r_tx_ready;
    logic       r_tx_underrun;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_overrun;

    logic       w_selected;
    logic       w_sample;
    logic       w_transmit;
    logic       w_last_bit;
    logic       w_rx_done;
    logic       w_do_load;
    logic [7:0] w_rx_word;
    logic [7:0] w_tx_next;
    logic [7:0] w_load_word;

    // Bit that leaves the shifter first for the configured bit order
    function automatic logic f_out_bit(input logic [7:0] word);
        return LSB_FIRST ? word[0] : word[7];
    endfunction

    // sample_edge has priority when both strobes collide
    assign w_selected  = ~bus.ss_n;
    assign w_sample    = bus.sample_edge;
    assign w_transmit  = bus.transmit_edge & ~bus.sample_edge;
    assign w_last_bit  = (r_rx_cnt == 3'd7);
    assign w_rx_done   = (r_state == ST_SHIFT) & w_selected & w_sample & w_last_bit;

    assign w_rx_word   = LSB_FIRST ? {bus.mosi_in, r_rx_shift[7:1]}
                                   : {r_rx_shift[6:0], bus.mosi_in};
    assign w_tx_next   = LSB_FIRST ? {1'b0, r_tx_shift[7:1]}
                                   : {r_tx_shift[6:0], 1'b0};
    assign w_load_word = bus.tx_valid ? bus.tx_data : 8'h00;

    // Word load points: the LOAD state, CPHA=1 frame completion, and the
    // first transmit_edge after completion when CPHA=0
    assign w_do_load = ((r_state == ST_LOAD) & w_selected)
                     | (w_rx_done & bus.cpha)
                     | ((r_state == ST_SHIFT) & w_selected & ~w_sample & w_transmit & r_reload);

    // Frame FSM and shift datapath; word loads override the state actions
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_tx_shift    <= 8'h00;
            r_rx_shift    <= 8'h00;
            r_rx_cnt      <= 3'd0;
            r_first_tx    <= 1'b0;
            r_reload      <= 1'b0;
            r_miso_out    <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rx_cnt   <= 3'd0;
                    r_rx_shift <= 8'h00;
                    r_first_tx <= 1'b0;
                    r_reload   <= 1'b0;
                    r_miso_out <= 1'b0;
                    r_miso_oe  <= 1'b0;
                    r_busy     <= 1'b0;
                    if (w_selected) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!w_selected) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= ST_SHIFT;
                        r_first_tx <= 1'b1;
                        r_reload   <= 1'b0;
                        r_miso_oe  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!w_selected) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_miso_oe  <= 1'b0;
                        r_miso_out <= 1'b0;
                        r_rx_cnt   <= 3'd0;
                        r_reload   <= 1'b0;
                    end else if (w_sample) begin
                        r_rx_shift <= w_rx_word;
                        r_rx_cnt   <= r_rx_cnt + 3'd1;
                        if (w_last_bit) begin
                            if (bus.cpha) begin
                                r_first_tx <= 1'b1;
                            end else begin
                                r_reload <= 1'b1;
                            end
                        end
                    end else if (w_transmit) begin
                        if (r_reload) begin
                            r_reload <= 1'b0;
                        end else if (bus.cpha && r_first_tx) begin
                            r_first_tx <= 1'b0;
                        end else begin
                            r_tx_shift <= w_tx_next;
                            r_miso_out <= f_out_bit(w_tx_next);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_do_load) begin
                r_tx_shift    <= w_load_word;
                r_miso_out    <= f_out_bit(w_load_word);
                r_tx_ready    <= bus.tx_valid;
                r_tx_underrun <= ~bus.tx_valid;
            end
        end
    end

    // Receive word handshake: capture on completion, clear on consume, flag overwrite
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (w_rx_done) begin
                r_rx_data    <= w_rx_word;
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= r_rx_valid & ~bus.rx_ready;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.tx_ready    = r_tx_ready;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_overrun  = r_rx_overrun;
    assign bus.miso_out    = r_miso_out;
    assign bus.miso_oe     = r_miso_oe;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// tb/tb_spi_slave_shifter.sv - bench for spi_slave_shifter, both bit orders side by side
`timescale 1ns/1ps

module tb_spi_slave_shifter;

    logic       pclk     = 1'b0;
    logic       presetn  = 1'b0;
    logic       ss_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic       cpha     = 1'b0;
    logic       se       = 1'b0;
    logic       te       = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_rdy_m = 0, n_rdy_l = 0, n_unr_m = 0, n_unr_l = 0, n_ovr_m = 0, n_ovr_l = 0;

    always #5 pclk = ~pclk;

    spi_slave_shifter_if if_m ();
    spi_slave_shifter_if if_l ();

    assign if_m.ss_n = ss_n;          assign if_l.ss_n = ss_n;
    assign if_m.mosi_in = mosi;       assign if_l.mosi_in = mosi;
    assign if_m.cpha = cpha;          assign if_l.cpha = cpha;
    assign if_m.sample_edge = se;     assign if_l.sample_edge = se;
    assign if_m.transmit_edge = te;   assign if_l.transmit_edge = te;
    assign if_m.tx_data = tx_data;    assign if_l.tx_data = tx_data;
    assign if_m.tx_valid = tx_valid;  assign if_l.tx_valid = tx_valid;
    assign if_m.rx_ready = rx_ready;  assign if_l.rx_ready = rx_ready;

    spi_slave_shifter #(.LSB_FIRST(1'b0)) u_msb (.pclk(pclk), .presetn(presetn), .bus(if_m.slave));
    spi_slave_shifter #(.LSB_FIRST(1'b1)) u_lsb (.pclk(pclk), .presetn(presetn), .bus(if_l.slave));

    // Pulse counters, sampled mid-cycle
    always @(negedge pclk) begin
        if (if_m.tx_ready)    n_rdy_m <= n_rdy_m + 1;
        if (if_l.tx_ready)    n_rdy_l <= n_rdy_l + 1;
        if (if_m.tx_underrun) n_unr_m <= n_unr_m + 1;
        if (if_l.tx_underrun) n_unr_l <= n_unr_l + 1;
        if (if_m.rx_overrun)  n_ovr_m <= n_ovr_m + 1;
        if (if_l.rx_overrun)  n_ovr_l <= n_ovr_l + 1;
    end

    typedef struct {
        logic       cpha;
        logic [7:0] tx;
        logic       txv;
        logic [7:0] mosi;
        logic [7:0] miso_m;
        logic [7:0] miso_l;
        logic [7:0] rx_m;
        logic [7:0] rx_l;
        int         rdy;
        int         unr;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_sample(input logic b);
        mosi = b;
        se   = 1'b1;
        tick();
        se   = 1'b0;
        tick();
    endtask

    task automatic pulse_tx();
        te = 1'b1;
        tick();
        te = 1'b0;
        tick();
    endtask

    // One frame of 8 sample strobes; MISO is recorded just before each sample
    // (first recorded bit lands in bit 7). CPHA=0 omits the trailing transmit
    // after the last sample so no reload happens inside this task.
    task automatic shift_byte(input logic [7:0] mb, output logic [7:0] sm, output logic [7:0] sl);
        for (int i = 0; i < 8; i++) begin
            if (cpha) pulse_tx();
            sm[7-i] = if_m.miso_out;
            sl[7-i] = if_l.miso_out;
            pulse_sample(mb[7-i]);
            if (!cpha && i != 7) pulse_tx();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sm, sl;
        int s_rdy_m, s_rdy_l, s_unr_m, s_unr_l, s_ovr_m, s_ovr_l;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 1, 0};
        vecs[1] = '{1'b1, 8'h01, 1'b1, 8'hFF, 8'h01, 8'h80, 8'hFF, 8'hFF, 1, 1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'hC1, 8'h00, 8'h00, 8'hC1, 8'h83, 0, 1};
        vecs[3] = '{1'b1, 8'h3A, 1'b1, 8'h12, 8'h3A, 8'h5C, 8'h12, 8'h48, 1, 1};
        vecs[4] = '{1'b0, 8'hC8, 1'b1, 8'h07, 8'hC8, 8'h13, 8'h07, 8'hE0, 1, 0};
        vecs[5] = '{1'b1, 8'h00, 1'b0, 8'h96, 8'h00, 8'h00, 8'h96, 8'h69, 0, 2};

        // Reset state
        repeat (3) tick();
        chk("rst_rx_data", if_m.rx_data, 8'h00);
        chk("rst_rx_valid", if_m.rx_valid, 1'b0);
        chk("rst_miso_oe", if_m.miso_oe, 1'b0);
        chk("rst_busy", if_l.busy, 1'b0);
        chk("rst_pulses", {if_m.tx_ready, if_m.tx_underrun, if_m.rx_overrun, if_m.miso_out}, 4'b0000);
        presetn = 1'b1;
        tick();
        chk("idle_busy", if_m.busy, 1'b0);

        // Single-frame vectors
        foreach (vecs[k]) begin
            s_rdy_m = n_rdy_m; s_rdy_l = n_rdy_l; s_unr_m = n_unr_m; s_unr_l = n_unr_l;
            cpha = vecs[k].cpha; tx_data = vecs[k].tx; tx_valid = vecs[k].txv;
            ss_n = 1'b0;
            tick();
            chk($sformatf("v%0d_busy_load", k), if_m.busy, 1'b1);
            chk($sformatf("v%0d_oe_load", k), if_m.miso_oe, 1'b0);
            tick();
            tx_valid = 1'b0;
            chk($sformatf("v%0d_oe_shift", k), {if_m.miso_oe, if_l.miso_oe}, 2'b11);
            shift_byte(vecs[k].mosi, sm, sl);
            chk($sformatf("v%0d_miso_m", k), sm, vecs[k].miso_m);
            chk($sformatf("v%0d_miso_l", k), sl, vecs[k].miso_l);
            chk($sformatf("v%0d_rx_m", k), if_m.rx_data, vecs[k].rx_m);
            chk($sformatf("v%0d_rx_l", k), if_l.rx_data, vecs[k].rx_l);
            chk($sformatf("v%0d_rx_valid", k), {if_m.rx_valid, if_l.rx_valid}, 2'b11);
            ss_n = 1'b1;
            tick();
            chk($sformatf("v%0d_oe_off", k), {if_m.miso_oe, if_l.miso_oe, if_m.busy}, 3'b000);
            chk($sformatf("v%0d_rdy_m", k), n_rdy_m - s_rdy_m, vecs[k].rdy);
            chk($sformatf("v%0d_rdy_l", k), n_rdy_l - s_rdy_l, vecs[k].rdy);
            chk($sformatf("v%0d_unr_m", k), n_unr_m - s_unr_m, vecs[k].unr);
            chk($sformatf("v%0d_unr_l", k), n_unr_l - s_unr_l, vecs[k].unr);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            chk($sformatf("v%0d_rx_consumed", k), {if_m.rx_valid, if_l.rx_valid}, 2'b00);
        end

        // CPHA=1 back-to-back frames, reload at completion
        s_rdy_l = n_rdy_l;
        cpha = 1'b1; tx_data = 8'h01; tx_valid = 1'b1; ss_n = 1'b0;
        tick(); tick();
        tx_data = 8'h80;
        shift_byte(8'hFF, sm, sl);
        tx_valid = 1'b0;
        chk("b2b_f1_miso_l", sl, 8'h80);
        chk("b2b_f1_miso_m", sm, 8'h01);
        chk("b2b_f1_rx_l", if_l.rx_data, 8'hFF);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        shift_byte(8'h00, sm, sl);
        chk("b2b_f2_miso_l", sl, 8'h01);
        chk("b2b_f2_miso_m", sm, 8'h80);
        chk("b2b_f2_rx_l", if_l.rx_data, 8'h00);
        chk("b2b_f2_rx_valid", if_l.rx_valid, 1'b1);
        chk("b2b_rdy_l", n_rdy_l - s_rdy_l, 2);
        ss_n = 1'b1; tick();
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;

        // CPHA=0 back-to-back with reload on transmit_edge, rx_ready held low
        s_rdy_m = n_rdy_m; s_ovr_m = n_ovr_m; s_ovr_l = n_ovr_l;
        cpha = 1'b0; tx_data = 8'h6B; tx_valid = 1'b1; ss_n = 1'b0;
        tick(); tick();
        tx_data = 8'h94;
        shift_byte(8'h11, sm, sl);
        chk("ovr_f1_miso_m", sm, 8'h6B);
        chk("ovr_f1_miso_l", sl, 8'hD6);
        chk("ovr_f1_rx_m", if_m.rx_data, 8'h11);
        chk("ovr_f1_no_ovr", n_ovr_m - s_ovr_m, 0);
        pulse_tx();
        tx_valid = 1'b0;
        shift_byte(8'h22, sm, sl);
        chk("ovr_f2_miso_m", sm, 8'h94);
        chk("ovr_f2_miso_l", sl, 8'h29);
        chk("ovr_rx_m", if_m.rx_data, 8'h22);
        chk("ovr_rx_l", if_l.rx_data, 8'h44);
        chk("ovr_rx_valid", {if_m.rx_valid, if_l.rx_valid}, 2'b11);
        chk("ovr_cnt_m", n_ovr_m - s_ovr_m, 1);
        chk("ovr_cnt_l", n_ovr_l - s_ovr_l, 1);
        chk("ovr_rdy_m", n_rdy_m - s_rdy_m, 2);
        ss_n = 1'b1; tick();
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;

        // Abort after 5 samples, then a fresh frame
        cpha = 1'b0; tx_data = 8'h55; tx_valid = 1'b1; ss_n = 1'b0;
        tick(); tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse_sample(1'b1);
            pulse_tx();
        end
        ss_n = 1'b1;
        tick();
        chk("abort_oe", {if_m.miso_oe, if_l.miso_oe, if_m.busy}, 3'b000);
        chk("abort_rx_valid", {if_m.rx_valid, if_l.rx_valid}, 2'b00);
        chk("abort_rx_data", if_m.rx_data, 8'h22);
        ss_n = 1'b0;
        tick(); tick();
        shift_byte(8'h5A, sm, sl);
        chk("abort_new_rx_m", if_m.rx_data, 8'h5A);
        chk("abort_new_rx_l", if_l.rx_data, 8'h5A);
        chk("abort_new_miso", sm, 8'h00);
        chk("abort_new_valid", if_m.rx_valid, 1'b1);

        // Asynchronous reset mid-frame with rx_valid set
        pulse_sample(1'b1);
        pulse_sample(1'b0);
        presetn = 1'b0;
        #1;
        chk("arst_rx_valid", {if_m.rx_valid, if_l.rx_valid}, 2'b00);
        chk("arst_rx_data", if_m.rx_data, 8'h00);
        chk("arst_outs", {if_m.miso_oe, if_m.busy, if_m.miso_out, if_l.busy}, 4'b0000);
        ss_n = 1'b1;
        tick();
        presetn = 1'b1;
        tick(); tick();
        chk("arst_idle", {if_m.busy, if_m.miso_oe}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

Byte-serial data path of the SPI slave, directly downstream of the SCLK edge receiver. It consumes the single-`pclk`-cycle `sample_edge`/`transmit_edge` strobes, shifts MOSI into a receive register and MISO out of a transmit register, and frames 8-bit words under slave select. It exchanges whole words with the APB-side buffers through a valid/ready transmit port and a valid/ready receive port, and reports underrun and overrun.

## Interface
- `LSB_FIRST`, default 0: 0 sends and receives MSB first; 1 sends and receives LSB first.
- `pclk  input  1  system clock; all state on rising edge`
- `presetn  input  1  asynchronous active-low reset`
- `ss_n  input  1  slave select, already synchronized to pclk, active low`
- `mosi_in  input  1  MOSI, already synchronized, aligned with sample_edge`
- `cpha  input  1  clock phase; static while ss_n low`
- `sample_edge  input  1  one-cycle strobe: capture mosi_in`
- `transmit_edge  input  1  one-cycle strobe: advance MISO`
- `tx_data  input  8  next word to transmit`
- `tx_valid  input  1  tx_data valid`
- `tx_ready  output  1  one-cycle pulse: tx_data consumed this cycle`
- `tx_underrun  output  1  one-cycle pulse: word needed, tx_valid low, 0x00 sent`
- `rx_data  output  8  last complete received word`
- `rx_valid  output  1  rx_data holds an unread word`
- `rx_ready  input  1  consumer takes rx_data when rx_valid & rx_ready`
- `rx_overrun  output  1  one-cycle pulse: unread word overwritten`
- `miso_out  output  1  current MISO bit`
- `miso_oe  output  1  MISO output enable; high only while selected`
- `busy  output  1  high in LOAD and SHIFT`

## Operation
- The FSM has three states: IDLE, LOAD and SHIFT.
- **IDLE**
  - `miso_oe`=0 and the bit counters are cleared.
  - `ss_n`=0 moves the FSM to LOAD.
- **LOAD** (exactly one cycle)
  - Performs a word load, then moves to SHIFT.
  - Any edge strobes arriving in this cycle are ignored.
- **Word load**
  - If `tx_valid`=1: `tx_shift`<=`tx_data` and `tx_ready`=1 in the same cycle.
  - If `tx_valid`=0: `tx_shift`<=0x00 and `tx_underrun`=1.
- **SHIFT**
  - `miso_oe`=1 and `busy`=1.
  - `miso_out` is the outgoing end of `tx_shift`: bit 7 when MSB first, bit 0 when LSB first.
- **Receive**
  - Each `sample_edge` shifts `mosi_in` into `rx_shift` and increments the 3-bit `rx_cnt`.
  - When the sample_edge arrives with `rx_cnt`=7, the frame completes:
    - `rx_data`<=assembled word (including the current bit);
    - `rx_valid`<=1;
    - `rx_cnt` wraps to 0.
- **Transmit**
  - Each `transmit_edge` shifts `tx_shift` by one toward the outgoing end.
  - Exception (CPHA=1): the first transmit_edge of every frame does not shift; it only presents the already-loaded first bit.
- **Reload point for back-to-back frames while `ss_n` stays low**
  - CPHA=0: the first transmit_edge after frame completion performs a word load instead of a shift.
  - CPHA=1: frame completion itself performs a word load in the same cycle as the rx capture.
- **`ss_n` high in LOAD or SHIFT**
  - The FSM returns to IDLE on the next cycle.
  - The partial frame is discarded: no `rx_valid`, and `rx_data` is unchanged.
  - Counters clear and `miso_oe` drops.
- **Receive handshake**
  - `rx_valid` clears on `rx_valid & rx_ready`.
  - Frame completes while `rx_valid`=1 and `rx_ready`=0: `rx_data` is overwritten, `rx_valid` stays 1, `rx_overrun`=1.
  - Frame completes in the same cycle as `rx_ready`=1: the old word is consumed, the new word is captured, `rx_valid` stays 1, and there is no overrun.
- **Simultaneous strobes**: `sample_edge` and `transmit_edge` are never asserted together. If they are, `sample_edge` wins and `transmit_edge` is dropped.

## Timing
- **Reset values**
  - All outputs are 0: `rx_data`=0x00, `rx_valid`=0, `miso_out`=0, `miso_oe`=0, `busy`=0, and all pulses 0.
  - FSM is in IDLE; `tx_shift` and `rx_shift` are 0.
- **Latencies**
  - `ss_n` fall to LOAD: 1 cycle.
  - LOAD to SHIFT: 1 cycle.
  - `miso_oe`=1 from the second cycle after `ss_n` is seen low.
- **Registered outputs**
  - `miso_out` changes the cycle after the strobe that moves it.
  - `rx_valid` and `rx_data` update the cycle after the completing sample_edge.
- `tx_ready`, `tx_underrun` and `rx_overrun` are single-cycle pulses, registered.
- Reset asserted mid-frame: all state returns to reset values immediately.
- The minimum supported strobe spacing is 2 `pclk` cycles.

## Test plan
- **Single frame, CPHA=0, MSB first**
  - Stimulus: `tx_valid`=1 with `tx_data`=0xA5; MOSI drives 0x3C over 8 sample/transmit pairs.
  - Response: MISO bit sequence 1,0,1,0,0,1,0,1; `rx_data`=0x3C; `rx_valid`=1; one `tx_ready` pulse.
- **CPHA=1, LSB_FIRST=1, two back-to-back frames**
  - Stimulus: `tx_data` 0x01 then 0x80; MOSI sends 0xFF then 0x00.
  - Response: the first transmit_edge does not shift; MISO is 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; `rx_data` is 0xFF then 0x00.
- **Underrun**
  - Stimulus: `tx_valid`=0 at `ss_n` fall.
  - Response: `tx_underrun` pulses once; MISO stays 0 for all 8 bits; `tx_ready` never asserts.
- **Overrun**
  - Stimulus: `rx_ready` held 0 across two frames receiving 0x11 then 0x22.
  - Response: `rx_overrun` pulses at the second completion; `rx_data`=0x22; `rx_valid` stays 1.
- **Abort**
  - Stimulus: `ss_n` rises after 5 sample_edges, then a new frame is received with MOSI 0x5A.
  - Response: no `rx_valid` for the partial frame; `miso_oe` drops the next cycle; the new frame yields 0x5A.
- **Reset**
  - Stimulus: `presetn` asserted mid-frame with `rx_valid`=1.
  - Response: all outputs 0 immediately; FSM in IDLE after release.
